mhvpis: RTL and testbench
=========================

# mhvpis

Multi-level hardware vectored priority interrupt system for the accumulator processor. It edge-detects four external interrupt lines, holds them pending, and applies a software mask and nested-priority rules. It presents a single request (`i_pending`) and an 8-bit vector to the stage 0 controller, and tracks in-service levels until the ISR signals return.

## Interface
- No parameters; 4 levels, vector base 8'hF0, and 4-byte vector spacing are fixed.
- `clk`  in  1  system clock, rising edge.
- `clr`  in  1  synchronous active-high reset.
- `irq`  in  4  interrupt lines; already synchronous to `clk`; bit 0 is highest priority.
- `mask_we`  in  1  load `mask` from `mask_in` this cycle.
- `mask_in`  in  4  new mask; 1 = level enabled.
- `i_ack`  in  1  one-cycle pulse from stage 0: vector taken, ISR entry begun.
- `i_done`  in  1  one-cycle pulse from stage 0: return-from-interrupt executed.
- `i_pending`  out  1  request to stage 0 (Moore; high only in state REQ).
- `i_vector`  out  8  ISR address: 8'hF0 + 4·level.
- `pend_out`  out  4  pending register (status).
- `isr_out`  out  4  in-service register (status).

## Operation
- Registers:
  - `prev[3:0]`: last `irq` sample.
  - `pend[3:0]`.
  - `mask[3:0]`.
  - `isr[3:0]`.
  - `lvl[1:0]`.
  - 2-bit state.
- Edge detect:
  - `rise = irq & ~prev`.
  - During `clr`, `prev` loads `irq`, so a line held high through reset produces no edge.
  - Level-high lines never re-trigger.
- Pending update each edge: `pend <= (pend & ~clr_bit) | rise`.
  - `clr_bit` is the acked level's one-hot; it is zero if there is no ack.
  - A new rise on the level being acked in the same cycle leaves that bit set.
- Ceiling: the index of the lowest set bit of `isr`, or 4 if `isr == 0`.
- Eligible set: `pend & mask` with index strictly below the ceiling.
- `best`: the lowest-index eligible bit.
- States:
  - IDLE (`i_pending` = 0):
    - If any eligible, go to REQ and load `lvl <= best`.
  - REQ (`i_pending` = 1):
    - Each cycle without ack, `lvl <= best`, so a higher-priority arrival before ack replaces the offered vector.
    - If the eligible set becomes empty (masked, or ceiling lowered), go to IDLE.
    - On `i_ack`: set `isr[lvl]`, clear `pend[lvl]`, go to HOLD.
  - HOLD (`i_pending` = 0): exactly one cycle, then IDLE. This guarantees stage 0 sees `i_pending` drop between grants.
- `i_done`:
  - Clears the lowest-index set bit of `isr`, computed from the registered value.
  - Ignored if `isr == 0`.
  - Accepted in any state.
- `i_ack` outside REQ is ignored.
- `i_ack` and `i_done` in the same cycle: both apply. Done clears the old highest in-service bit; ack sets `isr[lvl]`.
- `mask_we` takes effect on the edge; eligibility uses the new mask from the next cycle.
- Masked levels still latch into `pend` and are serviced once unmasked.
- `i_vector = {4'hF, lvl, 2'b00}`, registered; valid whenever `i_pending` = 1.

## Timing
- Reset values:
  - State IDLE.
  - `pend`, `isr`, and `mask` all 0000 (everything masked after reset).
  - `lvl` 0.
  - `i_pending` 0.
  - `i_vector` 8'hF0.
  - `pend_out` and `isr_out` 0.
- `clr` mid-operation (any state) returns to the reset values on the next edge. Any outstanding ack or done in that cycle is discarded.
- Latency:
  - `irq` rise sampled at edge k sets `pend` at edge k.
  - With the level enabled and eligible, `i_pending` is high after edge k+1, and `i_vector` is valid in the same cycle.
- `i_ack` sampled at edge m:
  - After edge m: `i_pending` = 0, `isr` updated.
  - The earliest following grant raises `i_pending` after edge m+2.
- `i_done` at edge m: `isr` is updated after edge m. A level previously blocked by the ceiling can reach REQ after edge m+1.

## Test plan
- Single request:
  - mask=1111; pulse `irq[2]`.
  - Expect `pend_out`=0100 after 1 edge, then `i_pending`=1 with `i_vector`=8'hF8 one edge later.
  - `i_ack` gives `isr_out`=0100, `pend_out`=0000, and `i_pending` low for ≥1 cycle.
- Priority:
  - `irq[3]` and `irq[1]` rise in the same cycle → vector 8'hF4.
  - After ack, HOLD, IDLE: level 3 stays blocked (ceiling 1) until `i_done`; then vector 8'hFC is offered.
- Nesting:
  - Level 2 in service; `irq[0]` rises → `i_pending`=1, vector 8'hF0.
  - Ack gives `isr_out`=0101.
  - First `i_done` gives 0100; second gives 0000.
- Pre-ack preemption:
  - In REQ offering 8'hFC, `irq[0]` rises → the next cycle offers 8'hF0.
  - Ack sets `isr[0]` only; `pend_out`=1000 remains.
- Mask in REQ:
  - Offering level 1 as the only eligible level, write mask=1101 → next cycle IDLE, `i_pending`=0, `pend_out` still 0010.
  - Re-enabling level 1 re-raises the request.
- Reset and edge cases:
  - `clr` in REQ → all outputs at reset values next cycle.
  - `irq` held high across `clr` release → `pend_out` stays 0000.
  - `i_done` with `isr`=0 → no change.

Source files
------------

// File: rtl/mhvpis_if.sv
// Interrupt-controller bus: external lines, mask load, and the request/vector
// handshake with the stage 0 controller.
interface mhvpis_if;
    logic [3:0] irq;
    logic       mask_we;
    logic [3:0] mask_in;
    logic       i_ack;
    logic       i_done;
    logic       i_pending;
    logic [7:0] i_vector;
    logic [3:0] pend_out;
    logic [3:0] isr_out;

    modport master (
        input  irq, mask_we, mask_in, i_ack, i_done,
        output i_pending, i_vector, pend_out, isr_out
    );

    modport slave (
        output irq, mask_we, mask_in, i_ack, i_done,
        input  i_pending, i_vector, pend_out, isr_out
    );
endinterface

// File: rtl/mhvpis.sv
// Four-level vectored priority interrupt controller with edge capture,
// software mask, and nested in-service ceiling.
module mhvpis (
    input logic      clk,
    input logic      clr,
    mhvpis_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t     state_q, state_d;
    logic [3:0] prev_q, prev_d;
    logic [3:0] pend_q, pend_d;
    logic [3:0] mask_q, mask_d;
    logic [3:0] isr_q, isr_d;
    logic [1:0] lvl_q, lvl_d;

    logic [3:0] rise;
    logic [3:0] isr_low;
    logic [3:0] below;
    logic [3:0] elig;
    logic [1:0] best;
    logic       ack_ok;
    logic [3:0] ack_bit;
    logic [3:0] done_bit;

    // Lowest set isr bit is the ceiling; everything under it may preempt.
    // With isr empty, isr_low is zero and below wraps to all ones.
    assign isr_low = isr_q & (~isr_q + 4'd1);
    assign below   = isr_low - 4'd1;
    assign elig    = pend_q & mask_q & below;
    assign rise    = bus.irq & ~prev_q;

    always_comb begin
        best = 2'd0;
        casez (elig)
            4'b???1: best = 2'd0;
            4'b??10: best = 2'd1;
            4'b?100: best = 2'd2;
            4'b1000: best = 2'd3;
            default: best = 2'd0;
        endcase
    end

    assign ack_ok   = (state_q == REQ) && bus.i_ack;
    assign ack_bit  = ack_ok ? (4'b0001 << lvl_q) : 4'b0000;
    assign done_bit = bus.i_done ? isr_low : 4'b0000;

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        prev_d  = bus.irq;
        pend_d  = (pend_q & ~ack_bit) | rise;
        mask_d  = bus.mask_we ? bus.mask_in : mask_q;
        isr_d   = (isr_q & ~done_bit) | ack_bit;
        unique case (state_q)
            IDLE: begin
                if (|elig) begin
                    state_d = REQ;
                    lvl_d   = best;
                end
            end
            REQ: begin
                if (ack_ok) begin
                    state_d = HOLD;
                end else if (elig == 4'b0000) begin
                    state_d = IDLE;
                end else begin
                    lvl_d = best;
                end
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clr) begin
            state_d = IDLE;
            lvl_d   = 2'd0;
            pend_d  = 4'b0000;
            mask_d  = 4'b0000;
            isr_d   = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        lvl_q   <= lvl_d;
        prev_q  <= prev_d;
        pend_q  <= pend_d;
        mask_q  <= mask_d;
        isr_q   <= isr_d;
    end

    assign bus.i_pending = (state_q == REQ);
    assign bus.i_vector  = {4'hF, lvl_q, 2'b00};
    assign bus.pend_out  = pend_q;
    assign bus.isr_out   = isr_q;
endmodule

// File: tb/tb_mhvpis.sv
// Directed bench for mhvpis: inputs change 1 time unit after a rising edge,
// outputs are sampled at the same point.
module tb_mhvpis;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int total = 0;
    int bad = 0;

    mhvpis_if bus ();

    mhvpis u_dut (
        .clk(clk),
        .clr(clr),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic do_clr();
        bus.irq = 4'b0000;
        bus.i_ack = 1'b0;
        bus.i_done = 1'b0;
        bus.mask_we = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        bus.mask_in = 4'b1111;
        bus.mask_we = 1'b1;
        tick();
        bus.mask_we = 1'b0;
    endtask

    task automatic test_reset();
        bus.irq = 4'b0000;
        bus.mask_we = 1'b0;
        bus.mask_in = 4'b0000;
        bus.i_ack = 1'b0;
        bus.i_done = 1'b0;
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        chk("rst_pending", {7'd0, bus.i_pending}, 8'h00);
        chk("rst_vector", bus.i_vector, 8'hF0);
        chk("rst_pend", {4'd0, bus.pend_out}, 8'h00);
        chk("rst_isr", {4'd0, bus.isr_out}, 8'h00);
        // mask is zero after reset: capture but never request
        bus.irq = 4'b0001;
        tick();
        bus.irq = 4'b0000;
        tick();
        tick();
        chk("masked_pend", {4'd0, bus.pend_out}, 8'h01);
        chk("masked_nopend", {7'd0, bus.i_pending}, 8'h00);
        bus.mask_in = 4'b1111;
        bus.mask_we = 1'b1;
        tick();
        bus.mask_we = 1'b0;
        tick();
        chk("unmask_req", {7'd0, bus.i_pending}, 8'h01);
        chk("unmask_vec", bus.i_vector, 8'hF0);
    endtask

    task automatic test_single();
        do_clr();
        bus.irq = 4'b0100;
        tick();
        bus.irq = 4'b0000;
        chk("single_pend", {4'd0, bus.pend_out}, 8'h04);
        chk("single_nopend", {7'd0, bus.i_pending}, 8'h00);
        tick();
        chk("single_req", {7'd0, bus.i_pending}, 8'h01);
        chk("single_vec", bus.i_vector, 8'hF8);
        bus.i_ack = 1'b1;
        tick();
        bus.i_ack = 1'b0;
        chk("single_isr", {4'd0, bus.isr_out}, 8'h04);
        chk("single_pend_clr", {4'd0, bus.pend_out}, 8'h00);
        chk("single_drop", {7'd0, bus.i_pending}, 8'h00);
        tick();
        chk("single_idle", {7'd0, bus.i_pending}, 8'h00);
        bus.i_done = 1'b1;
        tick();
        bus.i_done = 1'b0;
        chk("single_done", {4'd0, bus.isr_out}, 8'h00);
    endtask

    task automatic test_priority();
        do_clr();
        bus.irq = 4'b1010;
        tick();
        bus.irq = 4'b0000;
        chk("prio_pend", {4'd0, bus.pend_out}, 8'h0A);
        tick();
        chk("prio_req", {7'd0, bus.i_pending}, 8'h01);
        chk("prio_vec", bus.i_vector, 8'hF4);
        bus.i_ack = 1'b1;
        tick();
        bus.i_ack = 1'b0;
        chk("prio_isr", {4'd0, bus.isr_out}, 8'h02);
        chk("prio_pend3", {4'd0, bus.pend_out}, 8'h08);
        tick();
        tick();
        tick();
        chk("prio_blocked", {7'd0, bus.i_pending}, 8'h00);
        bus.i_done = 1'b1;
        tick();
        bus.i_done = 1'b0;
        chk("prio_done", {4'd0, bus.isr_out}, 8'h00);
        chk("prio_done_nopend", {7'd0, bus.i_pending}, 8'h00);
        tick();
        chk("prio_l3_req", {7'd0, bus.i_pending}, 8'h01);
        chk("prio_l3_vec", bus.i_vector, 8'hFC);
        bus.i_ack = 1'b1;
        tick();
        bus.i_ack = 1'b0;
        chk("prio_l3_isr", {4'd0, bus.isr_out}, 8'h08);
    endtask

    task automatic test_nesting();
        do_clr();
        bus.irq = 4'b0100;
        tick();
        bus.irq = 4'b0000;
        tick();
        bus.i_ack = 1'b1;
        tick();
        bus.i_ack = 1'b0;
        chk("nest_isr2", {4'd0, bus.isr_out}, 8'h04);
        tick();
        bus.irq = 4'b0001;
        tick();
        bus.irq = 4'b0000;
        tick();
        chk("nest_req", {7'd0, bus.i_pending}, 8'h01);
        chk("nest_vec", bus.i_vector, 8'hF0);
        bus.i_ack = 1'b1;
        tick();
        bus.i_ack = 1'b0;
        chk("nest_isr", {4'd0, bus.isr_out}, 8'h05);
        tick();
        bus.i_done = 1'b1;
        tick();
        chk("nest_done1", {4'd0, bus.isr_out}, 8'h04);
        tick();
        chk("nest_done2", {4'd0, bus.isr_out}, 8'h00);
        tick();
        bus.i_done = 1'b0;
        chk("done_empty_isr", {4'd0, bus.isr_out}, 8'h00);
        chk("done_empty_pend", {4'd0, bus.pend_out}, 8'h00);
        chk("done_empty_req", {7'd0, bus.i_pending}, 8'h00);
    endtask

    task automatic test_preempt();
        do_clr();
        bus.irq = 4'b1000;
        tick();
        bus.irq = 4'b0000;
        tick();
        chk("pre_vec3", bus.i_vector, 8'hFC);
        bus.irq = 4'b0001;
        tick();
        bus.irq = 4'b0000;
        chk("pre_vec_hold", bus.i_vector, 8'hFC);
        tick();
        chk("pre_req", {7'd0, bus.i_pending}, 8'h01);
        chk("pre_vec0", bus.i_vector, 8'hF0);
        bus.i_ack = 1'b1;
        tick();
        bus.i_ack = 1'b0;
        chk("pre_isr", {4'd0, bus.isr_out}, 8'h01);
        chk("pre_pend", {4'd0, bus.pend_out}, 8'h08);
        bus.i_done = 1'b1;
        tick();
        bus.i_done = 1'b0;
        chk("pre_done", {4'd0, bus.isr_out}, 8'h00);
        tick();
        chk("pre_l3_vec", bus.i_vector, 8'hFC);
        chk("pre_l3_req", {7'd0, bus.i_pending}, 8'h01);
    endtask

    task automatic test_mask_req();
        do_clr();
        bus.irq = 4'b0010;
        tick();
        bus.irq = 4'b0000;
        tick();
        chk("mask_req", {7'd0, bus.i_pending}, 8'h01);
        chk("mask_vec", bus.i_vector, 8'hF4);
        bus.mask_in = 4'b1101;
        bus.mask_we = 1'b1;
        tick();
        bus.mask_we = 1'b0;
        tick();
        chk("mask_drop", {7'd0, bus.i_pending}, 8'h00);
        chk("mask_pend", {4'd0, bus.pend_out}, 8'h02);
        bus.mask_in = 4'b1111;
        bus.mask_we = 1'b1;
        tick();
        bus.mask_we = 1'b0;
        tick();
        chk("mask_rereq", {7'd0, bus.i_pending}, 8'h01);
        chk("mask_revec", bus.i_vector, 8'hF4);
    endtask

    task automatic test_clr_edge();
        do_clr();
        bus.irq = 4'b1000;
        tick();
        bus.irq = 4'b0000;
        tick();
        chk("clr_pre_req", {7'd0, bus.i_pending}, 8'h01);
        // ack coincident with reset must be discarded
        bus.i_ack = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        bus.i_ack = 1'b0;
        chk("clr_pending", {7'd0, bus.i_pending}, 8'h00);
        chk("clr_vector", bus.i_vector, 8'hF0);
        chk("clr_pend", {4'd0, bus.pend_out}, 8'h00);
        chk("clr_isr", {4'd0, bus.isr_out}, 8'h00);
        bus.irq = 4'b0001;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        bus.mask_in = 4'b1111;
        bus.mask_we = 1'b1;
        tick();
        bus.mask_we = 1'b0;
        tick();
        tick();
        chk("held_pend", {4'd0, bus.pend_out}, 8'h00);
        chk("held_req", {7'd0, bus.i_pending}, 8'h00);
        bus.irq = 4'b0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_nesting();
        test_preempt();
        test_mask_req();
        test_clr_edge();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
